// File: rtl/mont_pkg.sv
// Shared constants and types for the Curve25519-field modular exponentiator.
package mont_pkg;

    // Field modulus p = 2^255 - 19 (low byte 0xED, all higher bits set)
    localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

    // Montgomery one: R mod p with R = 2^255
    localparam logic [254:0] R_MOD_P = 255'd19;

    // Bit-serial Montgomery multiplier processes one multiplier bit per cycle
    localparam int MUL_ITERS = 255;

    // Exponentiation ladder control states
    typedef enum logic [2:0] {
        IDLE,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        DONE
    } exp_state_t;

endpackage

// File: rtl/mont_exp_if.sv
// Request/response bundle between a requester and the exponentiator.
interface mont_exp_if #(
    parameter int EXP_BITS = 255
);
    logic                i_start;
    logic [254:0]        i_base;
    logic [EXP_BITS-1:0] i_exp;
    logic [254:0]        o_result;
    logic                o_finished;
    logic                o_busy;

    modport master (
        output i_start, i_base, i_exp,
        input  o_result, o_finished, o_busy
    );

    modport slave (
        input  i_start, i_base, i_exp,
        output o_result, o_finished, o_busy
    );
endinterface

// File: rtl/mont_exp_montgomery.sv
// Bit-serial Montgomery multiplier: o_result = a*b*2^-255 mod p.
// o_finished pulses exactly 257 cycles after the i_start cycle.
module Montgomery
    import mont_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_a,
    input  logic [254:0] i_b,
    output logic [254:0] o_result,
    output logic         o_finished
);

    logic [254:0] a_reg;
    logic [254:0] b_reg;
    logic [256:0] s_reg;
    logic [7:0]   cnt_reg;
    logic         run_reg;
    logic         red_reg;
    logic [254:0] result_reg;
    logic         finished_reg;

    logic [257:0] s_add;
    logic [257:0] s_odd;
    logic [256:0] s_step;
    logic [254:0] s_final;

    // One radix-2 reduction step; the partial sum stays below 2p throughout
    always_comb begin
        s_add   = {1'b0, s_reg} + (a_reg[0] ? {3'b000, b_reg} : 258'd0);
        s_odd   = s_add + (s_add[0] ? {3'b000, P} : 258'd0);
        s_step  = 257'(s_odd >> 1);
        s_final = (s_reg >= {2'b00, P}) ? 255'(s_reg - {2'b00, P}) : s_reg[254:0];
    end

    // Iterate 255 bits, then one conditional-subtract cycle, then the finish pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            s_reg        <= '0;
            cnt_reg      <= '0;
            run_reg      <= 1'b0;
            red_reg      <= 1'b0;
            result_reg   <= '0;
            finished_reg <= 1'b0;
        end else begin
            finished_reg <= 1'b0;
            if (run_reg) begin
                s_reg   <= s_step;
                a_reg   <= a_reg >> 1;
                cnt_reg <= cnt_reg + 8'd1;
                if (cnt_reg == 8'(MUL_ITERS - 1)) begin
                    run_reg <= 1'b0;
                    red_reg <= 1'b1;
                end
            end else if (red_reg) begin
                result_reg   <= s_final;
                finished_reg <= 1'b1;
                red_reg      <= 1'b0;
            end else if (i_start) begin
                a_reg   <= i_a;
                b_reg   <= i_b;
                s_reg   <= '0;
                cnt_reg <= '0;
                run_reg <= 1'b1;
            end
        end
    end

    assign o_result   = result_reg;
    assign o_finished = finished_reg;

endmodule

// File: rtl/mont_exp.sv
// Constant-time left-to-right square-and-multiply over p = 2^255-19,
// operating on Montgomery-form values with a single shared multiplier.
module mont_exp
    import mont_pkg::*;
#(
    parameter int EXP_BITS = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    mont_exp_if.slave  bus
);

    localparam int CNT_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

    exp_state_t          state_reg, state_next;
    logic [254:0]        acc_reg, acc_next;
    logic [254:0]        base_reg, base_next;
    logic [EXP_BITS-1:0] exp_reg, exp_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [254:0]        op_a_reg, op_a_next;
    logic [254:0]        op_b_reg, op_b_next;
    logic [254:0]        result_reg, result_next;
    logic                finished_reg, finished_next;
    logic                busy_reg, busy_next;

    logic                mul_start;
    logic [254:0]        mul_result;
    logic                mul_finished;
    logic [254:0]        acc_upd;

    Montgomery u_mul (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start),
        .i_a        (op_a_reg),
        .i_b        (op_b_reg),
        .o_result   (mul_result),
        .o_finished (mul_finished)
    );

    // Next-state and datapath control; the multiply is always issued so timing never depends on exp
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        base_next     = base_reg;
        exp_next      = exp_reg;
        bit_cnt_next  = bit_cnt_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        result_next   = result_reg;
        finished_next = 1'b0;
        busy_next     = busy_reg;
        mul_start     = 1'b0;
        acc_upd       = acc_reg;

        // busy covers the finished cycle and drops right after it
        if (finished_reg) begin
            busy_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (bus.i_start && !busy_reg) begin
                    base_next    = bus.i_base;
                    exp_next     = bus.i_exp;
                    acc_next     = R_MOD_P;
                    op_a_next    = R_MOD_P;
                    op_b_next    = R_MOD_P;
                    bit_cnt_next = CNT_W'(EXP_BITS - 1);
                    busy_next    = 1'b1;
                    state_next   = SQ_START;
                end
            end
            SQ_START: begin
                mul_start  = 1'b1;
                state_next = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mul_finished) begin
                    acc_next   = mul_result;
                    op_a_next  = mul_result;
                    op_b_next  = base_reg;
                    state_next = MUL_START;
                end
            end
            MUL_START: begin
                mul_start  = 1'b1;
                state_next = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_finished) begin
                    if (exp_reg[bit_cnt_reg]) begin
                        acc_upd = mul_result;
                    end
                    acc_next  = acc_upd;
                    op_a_next = acc_upd;
                    op_b_next = acc_upd;
                    if (bit_cnt_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg - CNT_W'(1);
                        state_next   = SQ_START;
                    end
                end
            end
            DONE: begin
                result_next   = acc_reg;
                finished_next = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            base_reg     <= '0;
            exp_reg      <= '0;
            bit_cnt_reg  <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            result_reg   <= '0;
            finished_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            base_reg     <= base_next;
            exp_reg      <= exp_next;
            bit_cnt_reg  <= bit_cnt_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            result_reg   <= result_next;
            finished_reg <= finished_next;
            busy_reg     <= busy_next;
        end
    end

    assign bus.o_result   = result_reg;
    assign bus.o_finished = finished_reg;
    assign bus.o_busy     = busy_reg;

endmodule
